// File: rtl/tx_completion_notifier_if.sv
// TRN TX port plus the request/grant pair to the TX arbiter, bundled so the
// notifier and its arbiter/core side connect through one port.
interface tx_completion_notifier_if;
  logic        notif_req;
  logic        notif_gnt;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [5:0]  trn_tbuf_av;

  modport master (
    output notif_req, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    input  notif_gnt, trn_tdst_rdy_n, trn_tbuf_av
  );

  modport slave (
    input  notif_req, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    output notif_gnt, trn_tdst_rdy_n, trn_tbuf_av
  );
endinterface

// File: rtl/tx_completion_notifier.sv
// Sends a 3-beat 64-bit-address MemWr TLP to the host completion buffer whenever
// huge page 1 and/or 2 has been freed, coalescing frees over a short window.
module tx_completion_notifier #(
  parameter logic [7:0]  NOTIF_TAG       = 8'hFE,
  parameter logic [2:0]  NOTIF_TC        = 3'd0,
  parameter int unsigned COALESCE_CYCLES = 16
) (
  input  logic                             trn_clk,
  input  logic                             reset_n,
  input  logic                             huge_page_free_1,
  input  logic                             huge_page_free_2,
  input  logic [63:0]                      completed_buffer_address,
  input  logic [15:0]                      cfg_completer_id,
  tx_completion_notifier_if.master         tx,
  output logic [31:0]                      notif_seq
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_HDR0 = 3'd3,
    S_HDR1 = 3'd4,
    S_DATA = 3'd5
  } state_e;

  localparam logic [15:0] COAL_LOAD = 16'(COALESCE_CYCLES);

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  cap_q, cap_d;
  logic [63:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] seq_q, seq_d;
  logic        req_q, req_d;
  logic [63:0] td_q, td_d;
  logic        sof_n_q, sof_n_d;
  logic        eof_n_q, eof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;

  logic [1:0]  frees_s;
  logic        accept_s;
  logic [63:0] hdr0_s;
  logic        unused_s;

  assign frees_s  = {huge_page_free_2, huge_page_free_1};
  assign accept_s = !src_rdy_n_q && !tx.trn_tdst_rdy_n;
  assign hdr0_s   = {1'b0, 7'b110_0000, 1'b0, NOTIF_TC, 4'b0000, 1'b0, 1'b0, 2'b00,
                     2'b00, 10'd2, cfg_completer_id, NOTIF_TAG, 4'hF, 4'hF};
  assign unused_s = ^{tx.trn_tbuf_av[5:2], tx.trn_tbuf_av[0], completed_buffer_address[1:0]};

  // Next-state and next-output logic; every output register is loaded here so the
  // TRN outputs come straight from flops and hold while a beat is stalled.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q | frees_s;
    cap_d       = cap_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    req_d       = req_q;
    td_d        = td_q;
    sof_n_d     = sof_n_q;
    eof_n_d     = eof_n_q;
    src_rdy_n_d = src_rdy_n_q;
    case (state_q)
      S_IDLE: begin
        // An unconfigured buffer address parks the block with pend held.
        if (((pend_q | frees_s) != 2'b00) && (completed_buffer_address != 64'd0)) begin
          state_d = S_WAIT;
          cnt_d   = COAL_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 16'd0) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_REQ: begin
        // Frees landing in the capture cycle stay pending for the next TLP.
        if (tx.notif_gnt && tx.trn_tbuf_av[1]) begin
          cap_d       = pend_q;
          pend_d      = frees_s;
          addr_d      = {completed_buffer_address[63:2], 2'b00};
          state_d     = S_HDR0;
          td_d        = hdr0_s;
          sof_n_d     = 1'b0;
          src_rdy_n_d = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HDR0: begin
        if (accept_s) begin
          state_d = S_HDR1;
          td_d    = addr_q;
          sof_n_d = 1'b1;
        end else begin
          state_d = S_HDR0;
        end
      end
      S_HDR1: begin
        if (accept_s) begin
          state_d = S_DATA;
          td_d    = {bswap32({30'd0, cap_q}), bswap32(seq_q)};
          eof_n_d = 1'b0;
        end else begin
          state_d = S_HDR1;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          state_d     = S_IDLE;
          seq_d       = seq_q + 32'd1;
          req_d       = 1'b0;
          td_d        = 64'd0;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_d       = 1'b0;
        td_d        = 64'd0;
        sof_n_d     = 1'b1;
        eof_n_d     = 1'b1;
        src_rdy_n_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 2'b00;
      cap_q       <= 2'b00;
      addr_q      <= 64'd0;
      cnt_q       <= 16'd0;
      seq_q       <= 32'd0;
      req_q       <= 1'b0;
      td_q        <= 64'd0;
      sof_n_q     <= 1'b1;
      eof_n_q     <= 1'b1;
      src_rdy_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cap_q       <= cap_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      req_q       <= req_d;
      td_q        <= td_d;
      sof_n_q     <= sof_n_d;
      eof_n_q     <= eof_n_d;
      src_rdy_n_q <= src_rdy_n_d;
    end
  end

  assign tx.notif_req      = req_q;
  assign tx.trn_td         = td_q;
  assign tx.trn_trem_n     = 8'h00;
  assign tx.trn_tsof_n     = sof_n_q;
  assign tx.trn_teof_n     = eof_n_q;
  assign tx.trn_tsrc_rdy_n = src_rdy_n_q;
  assign notif_seq         = seq_q;

endmodule

// File: tb/tb_tx_completion_notifier.sv
// Randomized and directed bench: free pulses are queued with the clock edge that
// samples them; a monitor rebuilds each expected TLP from that queue when a frame starts.
module tb_tx_completion_notifier;
  localparam int          C      = 16;
  localparam logic [15:0] CFG_ID = 16'hA5C3;

  typedef struct {
    int         stamp;
    logic [1:0] pages;
  } ev_t;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        f1 = 1'b0;
  logic        f2 = 1'b0;
  logic [63:0] addr_drv = 64'd0;
  logic [31:0] notif_seq;
  logic        gnt_tied = 1'b1;

  tx_completion_notifier_if tx();

  tx_completion_notifier #(
    .NOTIF_TAG(8'hFE), .NOTIF_TC(3'd0), .COALESCE_CYCLES(C)
  ) dut (
    .trn_clk                 (trn_clk),
    .reset_n                 (reset_n),
    .huge_page_free_1        (f1),
    .huge_page_free_2        (f2),
    .completed_buffer_address(addr_drv),
    .cfg_completer_id        (CFG_ID),
    .tx                      (tx),
    .notif_seq               (notif_seq)
  );

  always #5 trn_clk = ~trn_clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          edge_cnt = 0;
  logic [63:0] addr_at[int];
  ev_t         free_q[$];
  logic [31:0] model_seq = 32'd0;

  int          frames_done = 0;
  logic [1:0]  cap_log[$];
  logic [31:0] seq_log[$];
  int          start_log[$];
  int          stall_log[$];

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    forever begin
      @(posedge trn_clk);
      edge_cnt++;
      addr_at[edge_cnt] = addr_drv;
    end
  end

  initial begin
    tx.notif_gnt = 1'b0;
    forever begin
      @(posedge trn_clk);
      #1;
      if (gnt_tied) tx.notif_gnt = 1'b1;
      else if (!tx.notif_req) tx.notif_gnt = 1'b0;
      else if ($urandom_range(0, 3) == 0) tx.notif_gnt = 1'b1;
    end
  end

  // Monitor: checks each TLP beat against the model built from the free queue.
  int          beat = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_td;
  logic [1:0]  prev_se;
  logic [1:0]  exp_cap;
  logic [63:0] frame_addr;
  int          start_edge;
  int          stalls;
  initial begin
    ev_t ev;
    forever begin
      @(negedge trn_clk);
      if (!reset_n) begin
        beat = 0;
        prev_stall = 1'b0;
      end else if (!tx.trn_tsrc_rdy_n) begin
        if (prev_stall) begin
          check("hold_td", tx.trn_td, prev_td);
          check("hold_sof_eof", {tx.trn_tsof_n, tx.trn_teof_n}, prev_se);
        end else if (beat == 0) begin
          start_edge = edge_cnt;
          stalls = 0;
          exp_cap = 2'b00;
          while (free_q.size() > 0 && free_q[0].stamp < edge_cnt) begin
            ev = free_q.pop_front();
            exp_cap = exp_cap | ev.pages;
          end
          frame_addr = addr_at[edge_cnt];
        end
        if (!tx.trn_tdst_rdy_n) begin
          check("trem", tx.trn_trem_n, 8'h00);
          case (beat)
            0: begin
              check("hdr0_sof_eof", {tx.trn_tsof_n, tx.trn_teof_n}, 2'b01);
              check("hdr0", tx.trn_td, {32'h6000_0002, CFG_ID, 8'hFE, 8'hFF});
              beat = 1;
            end
            1: begin
              check("hdr1_sof_eof", {tx.trn_tsof_n, tx.trn_teof_n}, 2'b11);
              check("hdr1", tx.trn_td, {frame_addr[63:2], 2'b00});
              beat = 2;
            end
            default: begin
              check("data_sof_eof", {tx.trn_tsof_n, tx.trn_teof_n}, 2'b10);
              check("data", tx.trn_td, {bswap32({30'd0, exp_cap}), bswap32(model_seq)});
              cap_log.push_back(tx.trn_td[57:56]);
              seq_log.push_back(bswap32(tx.trn_td[31:0]));
              start_log.push_back(start_edge);
              stall_log.push_back(stalls);
              model_seq = model_seq + 32'd1;
              frames_done++;
              beat = 0;
            end
          endcase
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          stalls++;
        end
        prev_td = tx.trn_td;
        prev_se = {tx.trn_tsof_n, tx.trn_teof_n};
      end else begin
        if (beat != 0 || prev_stall) check("no_bubble", tx.trn_tsrc_rdy_n, 1'b0);
        prev_stall = 1'b0;
      end
    end
  end

  task automatic pulse(input logic p1, input logic p2);
    @(posedge trn_clk);
    #1;
    f1 = p1;
    f2 = p2;
    free_q.push_back('{stamp: edge_cnt + 1, pages: {p2, p1}});
    @(posedge trn_clk);
    #1;
    f1 = 1'b0;
    f2 = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge trn_clk);
      k++;
    end
    check(name, 64'(frames_done >= n), 64'd1);
  endtask

  task automatic wait_sof(input int budget);
    int k = 0;
    @(negedge trn_clk);
    while (tx.trn_tsof_n && k < budget) begin
      @(negedge trn_clk);
      k++;
    end
    check("sof_seen", tx.trn_tsof_n, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int s;
    tx.trn_tdst_rdy_n = 1'b0;
    tx.trn_tbuf_av    = 6'h3F;
    addr_drv          = 64'h0000_0001_2345_6780;
    repeat (3) @(posedge trn_clk);
    @(negedge trn_clk);
    check("rst_req", tx.notif_req, 1'b0);
    check("rst_src", tx.trn_tsrc_rdy_n, 1'b1);
    check("rst_sof_eof", {tx.trn_tsof_n, tx.trn_teof_n}, 2'b11);
    check("rst_td", tx.trn_td, 64'd0);
    check("rst_trem", tx.trn_trem_n, 8'h00);
    check("rst_seq", notif_seq, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge trn_clk);

    // Single free, immediate grant: latency and sequence number.
    base = frames_done;
    pulse(1'b1, 1'b0);
    s = edge_cnt;
    wait_frames(base + 1, 100, "t1_frame");
    check("t1_latency", 64'(start_log[$] - s), 64'(C + 2));
    check("t1_cap", cap_log[$], 2'b01);
    @(posedge trn_clk);
    #1;
    check("t1_seq_out", notif_seq, 32'd1);

    // Two frees inside one coalescing window give one TLP.
    base = frames_done;
    pulse(1'b1, 1'b0);
    repeat (3) @(posedge trn_clk);
    pulse(1'b0, 1'b1);
    wait_frames(base + 1, 200, "t2_frame");
    repeat (60) @(posedge trn_clk);
    check("t2_single", 64'(frames_done), 64'(base + 1));
    check("t2_cap", cap_log[$], 2'b11);

    // Destination stalls HDR1 for 4 cycles.
    base = frames_done;
    pulse(1'b1, 1'b0);
    wait_sof(100);
    @(posedge trn_clk);
    #1;
    tx.trn_tdst_rdy_n = 1'b1;
    repeat (4) @(posedge trn_clk);
    #1;
    tx.trn_tdst_rdy_n = 1'b0;
    wait_frames(base + 1, 100, "t3_frame");
    check("t3_stalls", 64'(stall_log[$]), 64'd4);

    // Unconfigured address holds the free until an address appears.
    addr_drv = 64'd0;
    repeat (3) @(posedge trn_clk);
    base = frames_done;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge trn_clk);
      check("t4_no_req", tx.notif_req, 1'b0);
    end
    @(posedge trn_clk);
    #1;
    addr_drv = 64'h0000_0000_0000_1000;
    wait_frames(base + 1, 100, "t4_frame");
    check("t4_cap", cap_log[$], 2'b10);

    // Random frees, stalls, grant delays, credit gaps and address changes.
    gnt_tied = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge trn_clk);
      #1;
      f1 = ($urandom_range(0, 24) == 0);
      f2 = ($urandom_range(0, 24) == 0);
      if (f1 || f2) free_q.push_back('{stamp: edge_cnt + 1, pages: {f2, f1}});
      tx.trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
      tx.trn_tbuf_av = 6'($urandom);
      tx.trn_tbuf_av[1] = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 199) == 0) addr_drv = {$urandom, $urandom} | 64'h100;
    end
    @(posedge trn_clk);
    #1;
    f1 = 1'b0;
    f2 = 1'b0;
    tx.trn_tdst_rdy_n = 1'b0;
    tx.trn_tbuf_av = 6'h3F;
    gnt_tied = 1'b1;
    repeat (120) @(posedge trn_clk);
    check("drain_empty", 64'(free_q.size()), 64'd0);

    // Reset during DATA, with a further free pending, abandons everything.
    base = frames_done;
    pulse(1'b1, 1'b0);
    wait_sof(100);
    @(posedge trn_clk);
    #1;
    f2 = 1'b1;
    free_q.push_back('{stamp: edge_cnt + 1, pages: 2'b10});
    @(posedge trn_clk);
    #1;
    f2 = 1'b0;
    check("t6_in_data", tx.trn_teof_n, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_src", tx.trn_tsrc_rdy_n, 1'b1);
    check("t6_sof_eof", {tx.trn_tsof_n, tx.trn_teof_n}, 2'b11);
    check("t6_td", tx.trn_td, 64'd0);
    check("t6_req", tx.notif_req, 1'b0);
    check("t6_seq", notif_seq, 32'd0);
    free_q.delete();
    model_seq = 32'd0;
    repeat (2) @(posedge trn_clk);
    @(negedge trn_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge trn_clk);
      check("t6_no_req", tx.notif_req, 1'b0);
    end
    check("t6_no_frame", 64'(frames_done), 64'(base));

    // Free in the capture cycle rides in a second TLP.
    base = frames_done;
    pulse(1'b0, 1'b1);
    s = edge_cnt;
    repeat (C + 1) @(posedge trn_clk);
    #1;
    f1 = 1'b1;
    free_q.push_back('{stamp: edge_cnt + 1, pages: 2'b01});
    @(posedge trn_clk);
    #1;
    f1 = 1'b0;
    wait_frames(base + 2, 300, "t5_frames");
    if (frames_done >= base + 2) begin
      check("t5_capture_edge", 64'(start_log[base]), 64'(s + C + 2));
      check("t5_cap0", cap_log[base], 2'b10);
      check("t5_cap1", cap_log[base + 1], 2'b01);
      check("t5_seq0", seq_log[base], 32'd0);
      check("t5_seq1", seq_log[base + 1], 32'd1);
    end
    repeat (5) @(posedge trn_clk);
    check("final_empty", 64'(free_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
